mac_dot_sequencer: RTL
======================

Name: mac_dot_sequencer

Overview:
Sequences one signed 16x16 multiply-accumulate unit (registered inputs, 32-bit accumulator, active-low clear, clock enable) to compute dot products of two vectors held in synchronous-read buffers. On a start command it clears the accumulator and streams LEN operand pairs into the MAC. It then waits out the MAC pipeline and presents the 32-bit result on a valid/ready output. It sits between the control/SPI register block and the MAC datapath.

Parameters:
ADDR_W, 8, buffer address width; vectors up to 2^ADDR_W elements
MAC_LAT, 3, cycles from a mac_ce-high cycle until that product is visible on mac_result

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  command strobe; sampled only in IDLE
len  in  ADDR_W+1  element count, 0..2^ADDR_W; latched on accepted start
a_base  in  ADDR_W  start address, buffer A; latched on accepted start
b_base  in  ADDR_W  start address, buffer B; latched on accepted start
busy  out  1  high in every state except IDLE
rd_en  out  1  read strobe to both buffers
rd_addr_a  out  ADDR_W  buffer A address
rd_addr_b  out  ADDR_W  buffer B address
rd_data_a  in  16  signed buffer A data, valid 1 cycle after rd_en
rd_data_b  in  16  signed buffer B data, valid 1 cycle after rd_en
mac_rst_n  out  1  MAC clear, active-low
mac_ce  out  1  MAC clock enable / operand valid
mac_a  out  16  signed operand A to MAC
mac_b  out  16  signed operand B to MAC
mac_result  in  32  signed MAC accumulator output
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  32  signed dot product

Behaviour:
- Reset: rst is the reset, synchronous, active-low; clk is the clock. While rst=0: state IDLE, busy=0, rd_en=0, rd_addr_a/b=0, mac_ce=0, mac_a/b=0, mac_rst_n=0, out_valid=0, out_result=0, counters=0.
- mac_rst_n = rst AND (state != CLEAR). It is combinational.
- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE: on start=1, latch len/a_base/b_base. If len!=0, go to CLEAR. If len==0, load out_result=0 and go to DONE; the MAC is untouched. start is ignored in all other states.
- CLEAR: exactly 1 cycle with mac_rst_n=0 (accumulator and MAC input registers cleared). Next state is STREAM with idx=0.
- STREAM: one cycle per element, no bubbles. rd_en=1, rd_addr_a=a_base+idx, rd_addr_b=b_base+idx, both modulo 2^ADDR_W. After issuing idx=len-1, go to DRAIN.
- Operand alignment: mac_ce is rd_en delayed 1 cycle. When mac_ce=1, mac_a=rd_data_a and mac_b=rd_data_b (passed through combinationally). When mac_ce=0, mac_a=mac_b=0.
- DRAIN: let T be the cycle holding the final mac_ce=1. DRAIN waits until cycle T+MAC_LAT, then registers mac_result into out_result and enters DONE.
- out_valid rises in cycle T+MAC_LAT+1.
- Total latency from the start cycle to out_valid is len+MAC_LAT+3 cycles.
- DONE: out_valid=1 and out_result stays stable until a cycle with out_valid AND out_ready. On that cycle, the next state is IDLE and out_valid=0. busy stays high through DONE.
- Arithmetic: out_result is the raw 32-bit two's-complement accumulator. It wraps on overflow; there is no saturation and no flag.
- len=2^ADDR_W: the full buffer is read once and the address wraps back to the base.
- Reset mid-operation: rst=0 in any state returns to IDLE on that edge. The partial result is discarded and mac_rst_n=0 clears the MAC.

Test Plan:
- A=[1,2,3,4], B=[5,6,7,8], len=4, bases 0 -> out_result=70. out_valid rises 4+MAC_LAT+3 cycles after start. rd_addr runs 0..3 on consecutive cycles.
- A=[-32768,-32768], B=[-32768,32767], len=2 -> out_result = 2^30 + (-32768*32767) = 0x00008000.
- len=0 with start -> no rd_en, no mac_ce, mac_rst_n stays high. out_valid=1 with out_result=0 on the cycle after start.
- Back-to-back runs: first result 70 with out_ready held low 10 cycles while start pulses -> out_result stable, starts ignored. After handshake, a new run A=[2], B=[3] -> 6; no carry-over from the previous accumulation.
- ADDR_W=8, a_base=254, b_base=0, len=4 -> rd_addr_a sequence 254,255,0,1; result matches the software model.
- Run len=16 and assert rst=0 for one cycle midway through STREAM -> IDLE, busy=0, out_valid=0. A subsequent run A=[1], B=[1] returns exactly 1.

Source files
------------

// File: rtl/mac_dot_sequencer.sv
// Dot-product sequencer: streams two buffer vectors through an external signed MAC,
// waits out the MAC pipeline and returns the 32-bit accumulator on a valid/ready port.
module mac_dot_sequencer #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned MAC_LAT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W:0]     len,
    input  logic [ADDR_W-1:0]   a_base,
    input  logic [ADDR_W-1:0]   b_base,
    output logic                busy,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr_a,
    output logic [ADDR_W-1:0]   rd_addr_b,
    input  logic signed [15:0]  rd_data_a,
    input  logic signed [15:0]  rd_data_b,
    output logic                mac_rst_n,
    output logic                mac_ce,
    output logic signed [15:0]  mac_a,
    output logic signed [15:0]  mac_b,
    input  logic signed [31:0]  mac_result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [31:0]  out_result
);

    localparam int unsigned IW = ADDR_W + 1;
    // Drain counter must reach MAC_LAT; extra bit keeps it at least 2 bits wide.
    localparam int unsigned DW = $clog2(MAC_LAT + 2) + 1;

    typedef enum logic [2:0] {StIdle, StClear, StStream, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [IW-1:0]      len_q, len_d;
    logic [ADDR_W-1:0]  a_base_q, a_base_d;
    logic [ADDR_W-1:0]  b_base_q, b_base_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic signed [31:0] result_q, result_d;
    logic               ce_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            len_q    <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            idx_q    <= '0;
            drain_q  <= '0;
            result_q <= '0;
            ce_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            a_base_q <= a_base_d;
            b_base_q <= b_base_d;
            idx_q    <= idx_d;
            drain_q  <= drain_d;
            result_q <= result_d;
            // Buffer data lands one cycle after the read, so the MAC enable trails rd_en.
            ce_q     <= (state_q == StStream);
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        a_base_d = a_base_q;
        b_base_d = b_base_q;
        idx_d    = idx_q;
        drain_d  = drain_q;
        result_d = result_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    len_d    = len;
                    a_base_d = a_base;
                    b_base_d = b_base;
                    if (len == '0) begin
                        result_d = '0;
                        state_d  = StDone;
                    end else begin
                        state_d = StClear;
                    end
                end
            end
            StClear: begin
                idx_d   = '0;
                state_d = StStream;
            end
            StStream: begin
                if (idx_q == len_q - IW'(1)) begin
                    drain_d = '0;
                    state_d = StDrain;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            StDrain: begin
                // First DRAIN cycle holds the last mac_ce; its product shows MAC_LAT later.
                if (drain_q == DW'(MAC_LAT)) begin
                    result_d = mac_result;
                    state_d  = StDone;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy       = rst && (state_q != StIdle);
        rd_en      = rst && (state_q == StStream);
        rd_addr_a  = rd_en ? a_base_q + idx_q[ADDR_W-1:0] : '0;
        rd_addr_b  = rd_en ? b_base_q + idx_q[ADDR_W-1:0] : '0;
        mac_rst_n  = rst && (state_q != StClear);
        mac_ce     = rst && ce_q;
        mac_a      = mac_ce ? rd_data_a : '0;
        mac_b      = mac_ce ? rd_data_b : '0;
        out_valid  = rst && (state_q == StDone);
        out_result = rst ? result_q : '0;
    end

endmodule
